// File: rtl/onehot2bin_decoder_if.sv
// Handshake bundle for the one-hot to binary decoder: request side, result side and error count.
interface onehot2bin_decoder_if #(
    parameter int BIN_WIDTH = 4,
    parameter int CNT_WIDTH = 8
);
    logic                      in_valid;
    logic                      in_ready;
    logic [2**BIN_WIDTH-1:0]   in_onehot;
    logic                      out_valid;
    logic                      out_ready;
    logic [BIN_WIDTH-1:0]      out_bin;
    logic                      out_err;
    logic [CNT_WIDTH-1:0]      err_count;

    modport master (
        output in_valid, in_onehot, out_ready,
        input  in_ready, out_valid, out_bin, out_err, err_count
    );

    modport slave (
        input  in_valid, in_onehot, out_ready,
        output in_ready, out_valid, out_bin, out_err, err_count
    );
endinterface

// File: rtl/onehot2bin_decoder.sv
// Registered one-hot to binary decoder with a 2-entry skid buffer and a saturating error counter.
module onehot2bin_decoder #(
    parameter int BIN_WIDTH = 4,
    parameter int CNT_WIDTH = 8
) (
    input logic                  clk,
    input logic                  reset,
    onehot2bin_decoder_if.slave  bus
);
    localparam int ONEHOT_WIDTH = 2**BIN_WIDTH;

    typedef struct packed {
        logic                 err;
        logic [BIN_WIDTH-1:0] bin;
    } res_t;

    res_t                 dec, main_q, skid_q;
    logic                 main_vld, skid_vld, skid_vld_nxt, rdy;
    logic                 accept, xfer, main_load;
    logic [CNT_WIDTH-1:0] cnt;

    // Descending scan so the lowest set bit wins on multi-hot inputs.
    always_comb begin
        dec = '0;
        for (int i = ONEHOT_WIDTH-1; i >= 0; i--)
            if (bus.in_onehot[i]) dec.bin = BIN_WIDTH'(i);
        dec.err = (bus.in_onehot == '0) ||
                  ((bus.in_onehot & (bus.in_onehot - ONEHOT_WIDTH'(1))) != '0);
    end

    assign accept    = bus.in_valid & rdy;
    assign xfer      = main_vld & bus.out_ready;
    assign main_load = xfer | ~main_vld;

    always_comb begin
        skid_vld_nxt = skid_vld;
        if (skid_vld && xfer)
            skid_vld_nxt = 1'b0;
        else if (!skid_vld && accept && !main_load)
            skid_vld_nxt = 1'b1;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            main_vld <= 1'b0;
            main_q   <= '0;
        end else if (main_load) begin
            if (skid_vld) begin
                main_q   <= skid_q;
                main_vld <= 1'b1;
            end else if (accept) begin
                main_q   <= dec;
                main_vld <= 1'b1;
            end else begin
                main_vld <= 1'b0;
            end
        end
    end

    // in_ready is registered from the next skid state, so out_ready never reaches it combinationally.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            skid_vld <= 1'b0;
            skid_q   <= '0;
            rdy      <= 1'b0;
        end else begin
            skid_vld <= skid_vld_nxt;
            rdy      <= ~skid_vld_nxt;
            if (!skid_vld && accept && !main_load)
                skid_q <= dec;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            cnt <= '0;
        else if (accept && dec.err && cnt != '1)
            cnt <= cnt + CNT_WIDTH'(1);
    end

    assign bus.in_ready  = rdy;
    assign bus.out_valid = main_vld;
    assign bus.out_bin   = main_q.bin;
    assign bus.out_err   = main_q.err;
    assign bus.err_count = cnt;
endmodule

// File: tb/tb_onehot2bin_decoder.sv
// Randomized and directed bench for onehot2bin_decoder against a queue-based reference model.
module tb_onehot2bin_decoder;
    logic clk = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    onehot2bin_decoder_if #(.BIN_WIDTH(4), .CNT_WIDTH(8)) bus ();
    onehot2bin_decoder_if #(.BIN_WIDTH(4), .CNT_WIDTH(2)) bus2 ();

    onehot2bin_decoder #(.BIN_WIDTH(4), .CNT_WIDTH(8)) dut  (.clk(clk), .reset(reset), .bus(bus));
    onehot2bin_decoder #(.BIN_WIDTH(4), .CNT_WIDTH(2)) dut2 (.clk(clk), .reset(reset), .bus(bus2));

    typedef struct { logic [3:0] bin; logic err; } res_t;
    res_t exp_q[$];
    int   n_chk = 0, n_fail = 0, n_err = 0, post = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic res_t ref_dec(input logic [15:0] x);
        res_t r;
        logic [15:0] lsb;
        lsb   = x & (~x + 16'd1);
        r.err = ($countones(x) != 1);
        r.bin = (x == 16'd0) ? 4'd0 : 4'($clog2(lsb));
        return r;
    endfunction

    always @(posedge clk) begin
        if (reset) post = 0;
        else       post++;
    end

    // Scoreboard: check what the last edge produced, then predict the coming edge.
    always @(negedge clk) begin
        if (reset) begin
            exp_q.delete();
            n_err = 0;
        end else begin
            chk("in_ready", bus.in_ready, (post > 0 && exp_q.size() < 2));
            chk("out_valid", bus.out_valid, exp_q.size() > 0);
            if (exp_q.size() > 0 && bus.out_valid) begin
                chk("out_bin", bus.out_bin, exp_q[0].bin);
                chk("out_err", bus.out_err, exp_q[0].err);
            end
            chk("err_count", bus.err_count, n_err);
            if (bus.out_valid && bus.out_ready && exp_q.size() > 0)
                void'(exp_q.pop_front());
            if (bus.in_valid && bus.in_ready) begin
                res_t r;
                r = ref_dec(bus.in_onehot);
                exp_q.push_back(r);
                if (r.err && n_err < 255) n_err++;
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v, input logic [15:0] oh, input logic ordy);
        bus.in_valid  = v;
        bus.in_onehot = oh;
        bus.out_ready = ordy;
    endtask

    initial begin
        logic [15:0] x;
        drive(1'b0, 16'h0, 1'b1);
        bus2.in_valid = 1'b0; bus2.in_onehot = 16'h0; bus2.out_ready = 1'b1;
        #1;
        chk("rst_out_valid", bus.out_valid, 0);
        chk("rst_out_bin", bus.out_bin, 0);
        chk("rst_out_err", bus.out_err, 0);
        chk("rst_err_count", bus.err_count, 0);
        chk("rst_in_ready", bus.in_ready, 0);
        repeat (3) tick();
        reset = 1'b0;
        tick();
        chk("ready_after_rst", bus.in_ready, 1);

        // Sweep of every single-hot position, back to back.
        for (int k = 0; k < 16; k++) begin
            x = 16'h0001 << k;
            drive(1'b1, x, 1'b1);
            tick();
            chk("sweep_bin", bus.out_bin, k);
            chk("sweep_err", bus.out_err, 0);
            chk("sweep_ready", bus.in_ready, 1);
        end

        // Zero-hot and multi-hot inputs.
        drive(1'b1, 16'h0000, 1'b1);
        tick();
        chk("zero_bin", bus.out_bin, 0);
        chk("zero_err", bus.out_err, 1);
        drive(1'b1, 16'h0A00, 1'b1);
        tick();
        chk("multi_bin", bus.out_bin, 9);
        chk("multi_err", bus.out_err, 1);
        drive(1'b0, 16'hFFFF, 1'b1);
        tick();
        chk("err_count_2", bus.err_count, 2);
        tick();

        // Backpressure fills main and skid, then drains in order.
        drive(1'b1, 16'h0008, 1'b0);
        tick();
        drive(1'b1, 16'h0100, 1'b0);
        tick();
        drive(1'b1, 16'h0002, 1'b0);
        tick();
        chk("bp_ready_low", bus.in_ready, 0);
        chk("bp_hold_bin", bus.out_bin, 3);
        tick();
        chk("bp_hold_bin2", bus.out_bin, 3);
        chk("bp_ready_low2", bus.in_ready, 0);
        bus.out_ready = 1'b1;
        tick();
        chk("bp_drain_8", bus.out_bin, 8);
        chk("bp_ready_back", bus.in_ready, 1);
        tick();
        chk("bp_drain_1", bus.out_bin, 1);
        drive(1'b0, 16'h0, 1'b1);
        repeat (2) tick();

        // Saturating counter on the narrow instance.
        for (int i = 0; i < 5; i++) begin
            bus2.in_valid = 1'b1;
            bus2.in_onehot = 16'h0000;
            tick();
            chk("sat_count", bus2.err_count, (i < 3) ? i + 1 : 3);
        end
        bus2.in_valid = 1'b0;

        // Reset between edges with both entries held.
        drive(1'b1, 16'h0004, 1'b0);
        tick();
        drive(1'b1, 16'h0010, 1'b0);
        tick();
        drive(1'b0, 16'h0, 1'b0);
        #2 reset = 1'b1;
        #1;
        chk("mid_rst_valid", bus.out_valid, 0);
        chk("mid_rst_count", bus.err_count, 0);
        chk("mid_rst_ready", bus.in_ready, 0);
        repeat (2) tick();
        reset = 1'b0;
        drive(1'b0, 16'h0, 1'b1);
        tick();
        chk("post_rst_empty", bus.out_valid, 0);
        drive(1'b1, 16'h0040, 1'b1);
        tick();
        chk("post_rst_valid", bus.out_valid, 1);
        chk("post_rst_bin", bus.out_bin, 6);
        drive(1'b0, 16'h0, 1'b1);
        tick();

        // Random traffic; the scoreboard checks every cycle.
        for (int c = 0; c < 1000; c++) begin
            case ($urandom_range(0, 3))
                0, 1: x = 16'h0001 << $urandom_range(0, 15);
                2:    x = 16'($urandom);
                default: x = ($urandom_range(0, 1) != 0) ? 16'h0000 : 16'($urandom) | 16'h0101;
            endcase
            drive(1'($urandom_range(0, 1)), x, ($urandom_range(0, 3) != 0));
            tick();
        end
        drive(1'b0, 16'h0, 1'b1);
        repeat (4) tick();
        chk("final_empty", bus.out_valid, 0);
        chk("final_err_count", bus.err_count, n_err);

        $display("Result: errors=%0d of %0d checks", n_fail, n_chk);
        $finish;
    end
endmodule
